// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and helpers for the CPU run monitor: FSM state encoding and a
// constant-foldable clog2 used to size index and count ports.
package cpu_run_monitor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_RUN     = 2'd1,
        MON_DONE    = 2'd2,
        MON_TIMEOUT = 2'd3
    } mon_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Monitor tap bus: CPU-side taps and trace read index in, status and trace entry out.
interface cpu_run_monitor_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
);
    import cpu_run_monitor_pkg::*;

    localparam int IDX_W  = clog2(DEPTH);
    localparam int TCNT_W = clog2(DEPTH + 1);

    logic              start;
    logic              fetch;
    logic              halt;
    logic              rf_we;
    logic [REG_W-1:0]  rf_wnum;
    logic [DATA_W-1:0] rf_wdata;
    logic [IDX_W-1:0]  rd_idx;
    logic              rd_valid;
    logic [REG_W-1:0]  rd_num;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        state;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  instr_cnt;
    logic [TCNT_W-1:0] trace_cnt;

    modport master (
        output start, fetch, halt, rf_we, rf_wnum, rf_wdata, rd_idx,
        input  rd_valid, rd_num, rd_data, state, cycle_cnt, instr_cnt, trace_cnt
    );

    modport slave (
        input  start, fetch, halt, rf_we, rf_wnum, rf_wdata, rd_idx,
        output rd_valid, rd_num, rd_data, state, cycle_cnt, instr_cnt, trace_cnt
    );

endinterface

// File: rtl/cpu_run_monitor_run_trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; the top masks stale entries with trace_cnt.
module run_trace_ram #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 19,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_run_monitor.sv
// In-circuit run checker: counts RUN cycles and fetches, detects halt/timeout,
// and keeps a circular trace of the most recent register-file writes.
module cpu_run_monitor
    import cpu_run_monitor_pkg::*;
#(
    parameter int DATA_W         = 16,
    parameter int REG_W          = 3,
    parameter int DEPTH          = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              reset,
    cpu_run_monitor_if.slave mon
);

    localparam int IDX_W  = clog2(DEPTH);
    localparam int TCNT_W = clog2(DEPTH + 1);
    localparam int ENT_W  = REG_W + DATA_W;

    localparam logic [CNT_W-1:0]  TO_LAST  = (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(DEPTH);

    mon_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
    logic [TCNT_W-1:0] trace_cnt;
    logic [IDX_W-1:0]  wr_ptr, rd_addr;
    logic [ENT_W-1:0]  rd_ent;
    logic              run_edge, rd_valid;

    // start overrides everything, so a RUN edge only counts when start is low
    assign run_edge = (state_q == MON_RUN) && !mon.start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= MON_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mon.start) begin
            state_d = MON_RUN;
        end else if (state_q == MON_RUN) begin
            if (mon.halt)
                state_d = MON_DONE;
            else if (TIMEOUT_CYCLES != 0 && cycle_cnt == TO_LAST)
                state_d = MON_TIMEOUT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            trace_cnt <= '0;
            wr_ptr    <= '0;
        end else if (mon.start) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
            trace_cnt <= '0;
            wr_ptr    <= '0;
        end else if (run_edge) begin
            if (cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 1'b1;
            if (mon.fetch && instr_cnt != '1)
                instr_cnt <= instr_cnt + 1'b1;
            if (mon.rf_we) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (trace_cnt != TCNT_MAX)
                    trace_cnt <= trace_cnt + 1'b1;
            end
        end
    end

    run_trace_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENT_W),
        .ADDR_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (run_edge && mon.rf_we),
        .waddr (wr_ptr),
        .wdata ({mon.rf_wnum, mon.rf_wdata}),
        .raddr (rd_addr),
        .rdata (rd_ent)
    );

    // index 0 is the slot just behind the write pointer; wrap is free for power-of-2 DEPTH
    assign rd_addr  = wr_ptr - IDX_W'(1) - mon.rd_idx;
    assign rd_valid = TCNT_W'(mon.rd_idx) < trace_cnt;

    assign mon.rd_valid  = rd_valid;
    assign mon.rd_num    = rd_valid ? rd_ent[ENT_W-1 -: REG_W] : '0;
    assign mon.rd_data   = rd_valid ? rd_ent[DATA_W-1:0] : '0;
    assign mon.state     = state_q;
    assign mon.cycle_cnt = cycle_cnt;
    assign mon.instr_cnt = instr_cnt;
    assign mon.trace_cnt = trace_cnt;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Directed bench for cpu_run_monitor: a vector table for trace wrap-around plus
// hand-written sequences for halt, timeout, restart and asynchronous reset.
module tb_cpu_run_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cpu_run_monitor_if #(.DATA_W(16), .REG_W(3), .DEPTH(8), .CNT_W(16)) bus ();

    cpu_run_monitor #(
        .DATA_W(16), .REG_W(3), .DEPTH(8), .CNT_W(16), .TIMEOUT_CYCLES(50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.fetch = 0; bus.halt = 0; bus.rf_we = 0;
        bus.rf_wnum = '0; bus.rf_wdata = '0;
    endtask

    // drive at negedge, let one posedge happen, settle, then drop pulses
    task automatic step(input logic st, input logic f, input logic h, input logic we,
                        input logic [2:0] num, input logic [15:0] data);
        @(negedge clk);
        bus.start = st; bus.fetch = f; bus.halt = h; bus.rf_we = we;
        bus.rf_wnum = num; bus.rf_wdata = data;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic read_at(input logic [2:0] idx);
        bus.rd_idx = idx;
        #1;
    endtask

    typedef struct {
        logic        st;
        logic        we;
        logic [2:0]  num;
        logic [15:0] data;
        logic [2:0]  idx;
        logic [1:0]  e_state;
        int          e_cyc;
        int          e_tcnt;
        logic        e_vld;
        logic [2:0]  e_num;
        logic [15:0] e_data;
    } vec_t;

    function automatic vec_t mk(logic st, logic we, logic [2:0] num, logic [15:0] data,
                                logic [2:0] idx, logic [1:0] es, int ec, int et,
                                logic ev, logic [2:0] en, logic [15:0] ed);
        vec_t v;
        v.st = st; v.we = we; v.num = num; v.data = data; v.idx = idx;
        v.e_state = es; v.e_cyc = ec; v.e_tcnt = et;
        v.e_vld = ev; v.e_num = en; v.e_data = ed;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        // start, then 10 writes of data k to R(k mod 8), then a read of the oldest
        // entry, then an 11th write that evicts data 3
        tbl[0]  = mk(1, 0, 0, 0,  0, 1, 0,  0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1,  0, 1, 1,  1, 1, 1, 1);
        tbl[2]  = mk(0, 1, 2, 2,  0, 1, 2,  2, 1, 2, 2);
        tbl[3]  = mk(0, 1, 3, 3,  0, 1, 3,  3, 1, 3, 3);
        tbl[4]  = mk(0, 1, 4, 4,  0, 1, 4,  4, 1, 4, 4);
        tbl[5]  = mk(0, 1, 5, 5,  0, 1, 5,  5, 1, 5, 5);
        tbl[6]  = mk(0, 1, 6, 6,  0, 1, 6,  6, 1, 6, 6);
        tbl[7]  = mk(0, 1, 7, 7,  0, 1, 7,  7, 1, 7, 7);
        tbl[8]  = mk(0, 1, 0, 8,  0, 1, 8,  8, 1, 0, 8);
        tbl[9]  = mk(0, 1, 1, 9,  0, 1, 9,  8, 1, 1, 9);
        tbl[10] = mk(0, 1, 2, 10, 0, 1, 10, 8, 1, 2, 10);
        tbl[11] = mk(0, 0, 0, 0,  7, 1, 11, 8, 1, 3, 3);
        tbl[12] = mk(0, 1, 3, 11, 7, 1, 12, 8, 1, 4, 4);

        clear_inputs();
        bus.rd_idx = '0;

        // 1: reset, then 20 idle cycles without start
        #12;
        @(negedge clk);
        reset = 0;
        repeat (20) step(0, 0, 0, 0, 0, 0);
        read_at(0);
        check("t1_state", bus.state, 0);
        check("t1_cycle", bus.cycle_cnt, 0);
        check("t1_instr", bus.instr_cnt, 0);
        check("t1_tcnt", bus.trace_cnt, 0);
        check("t1_rd_valid", bus.rd_valid, 0);

        // 2: 5 fetches, 3 writes, halt on the 30th RUN edge
        step(1, 0, 0, 0, 0, 0);
        check("t2_run", bus.state, 1);
        for (int e = 1; e <= 30; e++) begin
            case (e)
                2:       step(0, 0, 0, 1, 0, 16'h0007);
                4:       step(0, 0, 0, 1, 1, 16'h000E);
                6:       step(0, 0, 0, 1, 2, 16'h0011);
                30:      step(0, 0, 1, 0, 0, 0);
                default: step(0, (e <= 9) && (e % 2 == 1), 0, 0, 0, 0);
            endcase
        end
        check("t2_state", bus.state, 2);
        check("t2_cycle", bus.cycle_cnt, 30);
        check("t2_instr", bus.instr_cnt, 5);
        check("t2_tcnt", bus.trace_cnt, 3);
        read_at(0);
        check("t2_idx0_num", bus.rd_num, 2);
        check("t2_idx0_data", bus.rd_data, 16'h0011);
        read_at(2);
        check("t2_idx2_num", bus.rd_num, 0);
        check("t2_idx2_data", bus.rd_data, 16'h0007);
        read_at(3);
        check("t2_idx3_valid", bus.rd_valid, 0);
        check("t2_idx3_data", bus.rd_data, 0);
        // DONE must ignore taps
        step(0, 1, 0, 1, 5, 16'h1234);
        check("t2_frozen_cycle", bus.cycle_cnt, 30);
        check("t2_frozen_instr", bus.instr_cnt, 5);
        check("t2_frozen_tcnt", bus.trace_cnt, 3);

        // 3: table-driven trace wrap
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            bus.start = tbl[i].st; bus.rf_we = tbl[i].we;
            bus.rf_wnum = tbl[i].num; bus.rf_wdata = tbl[i].data;
            bus.rd_idx = tbl[i].idx;
            if (i == 12) begin
                #1;
                check("t3_old_before_edge", bus.rd_data, 3);
            end
            @(posedge clk);
            #1;
            clear_inputs();
            check($sformatf("t3_v%0d_state", i), bus.state, tbl[i].e_state);
            check($sformatf("t3_v%0d_cycle", i), bus.cycle_cnt, tbl[i].e_cyc);
            check($sformatf("t3_v%0d_tcnt", i), bus.trace_cnt, tbl[i].e_tcnt);
            check($sformatf("t3_v%0d_valid", i), bus.rd_valid, tbl[i].e_vld);
            check($sformatf("t3_v%0d_num", i), bus.rd_num, tbl[i].e_num);
            check($sformatf("t3_v%0d_data", i), bus.rd_data, tbl[i].e_data);
        end
        bus.rd_idx = '0;

        // 4: timeout after exactly 50 RUN edges, then a rerun halting on edge 50
        step(1, 0, 0, 0, 0, 0);
        repeat (49) step(0, 0, 0, 0, 0, 0);
        check("t4_still_run", bus.state, 1);
        check("t4_cycle49", bus.cycle_cnt, 49);
        step(0, 0, 0, 0, 0, 0);
        check("t4_timeout", bus.state, 3);
        check("t4_cycle50", bus.cycle_cnt, 50);
        step(0, 1, 0, 0, 0, 0);
        check("t4_frozen", bus.cycle_cnt, 50);
        step(1, 0, 0, 0, 0, 0);
        repeat (49) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        check("t4_halt_wins", bus.state, 2);
        check("t4_halt_cycle", bus.cycle_cnt, 50);

        // 5: write and halt on the same edge, then restart from DONE
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 7, 16'h00A6);
        check("t5_state", bus.state, 2);
        check("t5_tcnt", bus.trace_cnt, 1);
        check("t5_instr", bus.instr_cnt, 1);
        read_at(0);
        check("t5_idx0_num", bus.rd_num, 7);
        check("t5_idx0_data", bus.rd_data, 16'h00A6);
        step(1, 0, 0, 0, 0, 0);
        check("t5_restart_state", bus.state, 1);
        check("t5_restart_cycle", bus.cycle_cnt, 0);
        check("t5_restart_instr", bus.instr_cnt, 0);
        check("t5_restart_tcnt", bus.trace_cnt, 0);

        // 6: asynchronous reset mid-RUN, between edges
        step(0, 1, 0, 1, 3, 16'h0033);
        step(0, 1, 0, 1, 4, 16'h0044);
        check("t6_pre_tcnt", bus.trace_cnt, 2);
        @(negedge clk);
        #2;
        reset = 1;
        #1;
        check("t6_async_state", bus.state, 0);
        check("t6_async_tcnt", bus.trace_cnt, 0);
        check("t6_async_cycle", bus.cycle_cnt, 0);
        @(negedge clk);
        reset = 0;
        repeat (3) step(0, 1, 0, 1, 1, 16'h0001);
        check("t6_idle_state", bus.state, 0);
        check("t6_idle_instr", bus.instr_cnt, 0);
        check("t6_idle_cycle", bus.cycle_cnt, 0);
        check("t6_idle_tcnt", bus.trace_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
